// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer scheduler: hands out frame buffers to one stream writer and one
// stream reader, publishes the newest completed frame and counts drops/repeats.
module frame_buffer_scheduler #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [C_ADDR_WIDTH-1:0] base_addr,
  input  logic [C_ADDR_WIDTH-1:0] frame_size,
  output logic                    s2mm_soft_resetn,
  input  logic                    s2mm_resetting,
  input  logic                    s2mm_sof,
  output logic [C_ADDR_WIDTH-1:0] s2mm_addr,
  output logic                    mm2s_soft_resetn,
  input  logic                    mm2s_resetting,
  input  logic                    mm2s_sof,
  output logic [C_ADDR_WIDTH-1:0] mm2s_addr,
  output logic                    rd_frame_valid,
  output logic [1:0]              wr_idx,
  output logic [1:0]              rd_idx,
  output logic [C_CNT_WIDTH-1:0]  drop_cnt,
  output logic [C_CNT_WIDTH-1:0]  repeat_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    stop_seen_q;
  logic [1:0]              w_q, w_d, l_q, l_d, r_q, r_d;
  logic                    fresh_q, fresh_d;
  logic                    started_q, started_d;
  logic                    rfv_q, rfv_d;
  logic [C_CNT_WIDTH-1:0]  drop_q, drop_d, rep_q, rep_d;
  logic [C_ADDR_WIDTH-1:0] buf0_q, buf1_q, buf2_q;
  logic [C_ADDR_WIDTH-1:0] s2mm_addr_q, mm2s_addr_q;
  logic                    s2mm_srn_q, mm2s_srn_q;
  logic                    run_s, publish_s, take_s;

  function automatic logic [C_ADDR_WIDTH-1:0] sel_buf(
    input logic [1:0]              idx,
    input logic [C_ADDR_WIDTH-1:0] b0,
    input logic [C_ADDR_WIDTH-1:0] b1,
    input logic [C_ADDR_WIDTH-1:0] b2
  );
    case (idx)
      2'd0:    sel_buf = b0;
      2'd1:    sel_buf = b1;
      2'd2:    sel_buf = b2;
      default: sel_buf = b0;
    endcase
  endfunction

  assign run_s     = (state_q == ST_RUN);
  // The first writer frame after RUN entry only claims W; it has nothing to publish yet.
  assign publish_s = run_s & s2mm_sof & started_q;
  assign take_s    = run_s & mm2s_sof;

  // Run/stop sequencing with a minimum two-cycle drain window in STOP
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!enable) state_d = ST_STOP;
        else         state_d = ST_RUN;
      end
      ST_STOP: begin
        if (stop_seen_q && !s2mm_resetting && !mm2s_resetting) state_d = ST_IDLE;
        else                                                   state_d = ST_STOP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Buffer ownership rotation and status counters
  always_comb begin
    w_d       = w_q;
    l_d       = l_q;
    r_d       = r_q;
    fresh_d   = fresh_q;
    rfv_d     = rfv_q;
    drop_d    = drop_q;
    rep_d     = rep_q;
    started_d = (state_d != ST_IDLE) && (started_q || (run_s && s2mm_sof));
    if (state_d == ST_IDLE) begin
      w_d     = 2'd0;
      l_d     = 2'd1;
      r_d     = 2'd2;
      fresh_d = 1'b0;
      rfv_d   = 1'b0;
    end else if (publish_s && take_s) begin
      // Reader takes the just-finished frame directly; writer reuses the reader's old buffer.
      w_d     = r_q;
      r_d     = w_q;
      fresh_d = 1'b0;
      rfv_d   = 1'b1;
    end else if (publish_s) begin
      w_d     = l_q;
      l_d     = w_q;
      fresh_d = 1'b1;
      if (fresh_q) drop_d = drop_q + C_CNT_WIDTH'(1);
      else         drop_d = drop_q;
    end else if (take_s) begin
      if (fresh_q) begin
        r_d     = l_q;
        l_d     = r_q;
        fresh_d = 1'b0;
        rfv_d   = 1'b1;
      end else begin
        rep_d = rep_q + C_CNT_WIDTH'(1);
      end
    end else begin
      w_d = w_q;
    end
  end

  // Control state, ownership and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      stop_seen_q <= 1'b0;
      w_q         <= 2'd0;
      l_q         <= 2'd1;
      r_q         <= 2'd2;
      fresh_q     <= 1'b0;
      started_q   <= 1'b0;
      rfv_q       <= 1'b0;
      drop_q      <= {C_CNT_WIDTH{1'b0}};
      rep_q       <= {C_CNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      stop_seen_q <= (state_q == ST_STOP);
      w_q         <= w_d;
      l_q         <= l_d;
      r_q         <= r_d;
      fresh_q     <= fresh_d;
      started_q   <= started_d;
      rfv_q       <= rfv_d;
      drop_q      <= drop_d;
      rep_q       <= rep_d;
    end
  end

  // Address table and registered engine-facing outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      buf0_q      <= {C_ADDR_WIDTH{1'b0}};
      buf1_q      <= {C_ADDR_WIDTH{1'b0}};
      buf2_q      <= {C_ADDR_WIDTH{1'b0}};
      s2mm_addr_q <= {C_ADDR_WIDTH{1'b0}};
      mm2s_addr_q <= {C_ADDR_WIDTH{1'b0}};
      s2mm_srn_q  <= 1'b0;
      mm2s_srn_q  <= 1'b0;
    end else begin
      buf0_q      <= base_addr;
      buf1_q      <= base_addr + frame_size;
      buf2_q      <= base_addr + (frame_size << 1);
      s2mm_addr_q <= sel_buf(w_d, buf0_q, buf1_q, buf2_q);
      mm2s_addr_q <= sel_buf(r_d, buf0_q, buf1_q, buf2_q);
      s2mm_srn_q  <= (state_d == ST_RUN);
      mm2s_srn_q  <= (state_d == ST_RUN);
    end
  end

  assign s2mm_soft_resetn = s2mm_srn_q;
  assign mm2s_soft_resetn = mm2s_srn_q;
  assign s2mm_addr        = s2mm_addr_q;
  assign mm2s_addr        = mm2s_addr_q;
  assign rd_frame_valid   = rfv_q;
  assign wr_idx           = w_q;
  assign rd_idx           = r_q;
  assign drop_cnt         = drop_q;
  assign repeat_cnt       = rep_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Bench for frame_buffer_scheduler: directed vector table, hand sequences for
// stop/drain and reset, then random stimulus against a behavioural model.
module tb_frame_buffer_scheduler;
  localparam int AW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset, enable, s2mm_resetting, s2mm_sof, mm2s_resetting, mm2s_sof;
  logic [AW-1:0] base_addr, frame_size, s2mm_addr, mm2s_addr;
  logic          s2mm_soft_resetn, mm2s_soft_resetn, rd_frame_valid;
  logic [1:0]    wr_idx, rd_idx;
  logic [CW-1:0] drop_cnt, repeat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_buffer_scheduler #(.C_ADDR_WIDTH(AW), .C_CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .base_addr(base_addr), .frame_size(frame_size),
    .s2mm_soft_resetn(s2mm_soft_resetn), .s2mm_resetting(s2mm_resetting),
    .s2mm_sof(s2mm_sof), .s2mm_addr(s2mm_addr),
    .mm2s_soft_resetn(mm2s_soft_resetn), .mm2s_resetting(mm2s_resetting),
    .mm2s_sof(mm2s_sof), .mm2s_addr(mm2s_addr),
    .rd_frame_valid(rd_frame_valid), .wr_idx(wr_idx), .rd_idx(rd_idx),
    .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt)
  );

  // Reference model: roles of the three buffers plus run/stop mode.
  int            m_mode;   // 0 idle, 1 run, 2 stop
  int            m_stop_cycles;
  int            m_w, m_l, m_r;
  bit            m_fresh, m_started, m_valid;
  logic [CW-1:0] m_drop, m_rep;
  logic [AW-1:0] m_tbl_base, m_tbl_size, m_wa, m_ra;

  task automatic model_step();
    int t;
    bit pub;
    if (reset) begin
      m_mode = 0; m_stop_cycles = 0;
      m_w = 0; m_l = 1; m_r = 2;
      m_fresh = 0; m_started = 0; m_valid = 0;
      m_drop = '0; m_rep = '0;
      m_tbl_base = '0; m_tbl_size = '0; m_wa = '0; m_ra = '0;
      return;
    end
    if (m_mode == 1) begin
      pub = s2mm_sof && m_started;
      if (s2mm_sof) m_started = 1;
      if (pub && mm2s_sof) begin
        t = m_w; m_w = m_r; m_r = t; m_fresh = 0; m_valid = 1;
      end else begin
        if (pub) begin
          if (m_fresh) m_drop = m_drop + 1'b1;
          t = m_w; m_w = m_l; m_l = t; m_fresh = 1;
        end
        if (mm2s_sof) begin
          if (m_fresh) begin
            t = m_r; m_r = m_l; m_l = t; m_fresh = 0; m_valid = 1;
          end else begin
            m_rep = m_rep + 1'b1;
          end
        end
      end
      if (!enable) begin m_mode = 2; m_stop_cycles = 0; end
    end else if (m_mode == 2) begin
      if (m_stop_cycles >= 1 && !s2mm_resetting && !mm2s_resetting) m_mode = 0;
      else m_stop_cycles++;
    end else begin
      if (enable) m_mode = 1;
    end
    if (m_mode == 0) begin
      m_w = 0; m_l = 1; m_r = 2; m_fresh = 0; m_started = 0; m_valid = 0;
    end
    m_wa = m_tbl_base + 32'(m_w) * m_tbl_size;
    m_ra = m_tbl_base + 32'(m_r) * m_tbl_size;
    m_tbl_base = base_addr;
    m_tbl_size = frame_size;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model(input int c);
    chk($sformatf("rnd%0d_wr_idx", c), 32'(wr_idx), 32'(m_w));
    chk($sformatf("rnd%0d_rd_idx", c), 32'(rd_idx), 32'(m_r));
    chk($sformatf("rnd%0d_valid", c), 32'(rd_frame_valid), 32'(m_valid));
    chk($sformatf("rnd%0d_s2mm_srn", c), 32'(s2mm_soft_resetn), 32'(m_mode == 1));
    chk($sformatf("rnd%0d_mm2s_srn", c), 32'(mm2s_soft_resetn), 32'(m_mode == 1));
    chk($sformatf("rnd%0d_drop", c), 32'(drop_cnt), 32'(m_drop));
    chk($sformatf("rnd%0d_repeat", c), 32'(repeat_cnt), 32'(m_rep));
    chk($sformatf("rnd%0d_s2mm_addr", c), s2mm_addr, m_wa);
    chk($sformatf("rnd%0d_mm2s_addr", c), mm2s_addr, m_ra);
  endtask

  typedef struct {
    logic rst, en, ws, rs;
    logic [1:0] w, r;
    logic v, srn;
    logic [15:0] drop, rep;
    logic [31:0] wa, ra;
  } vec_t;

  vec_t vt[16];

  initial begin
    reset = 1'b1; enable = 1'b0; s2mm_sof = 1'b0; mm2s_sof = 1'b0;
    s2mm_resetting = 1'b0; mm2s_resetting = 1'b0;
    base_addr = 32'h1000_0000; frame_size = 32'h0010_0000;

    //        rst   en    ws    rs    w     r     v     srn   drop   rep    wa            ra
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 16'd0, 16'd0, 32'h0,        32'h0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 16'd0, 16'd0, 32'h0,        32'h0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 16'd0, 16'd0, 32'h1000_0000, 32'h1020_0000};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 16'd0, 16'd0, 32'h1000_0000, 32'h1020_0000};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 16'd0, 16'd0, 32'h1000_0000, 32'h1020_0000};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0, 1'b1, 16'd0, 16'd0, 32'h1010_0000, 32'h1020_0000};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 1'b1, 1'b1, 16'd0, 16'd0, 32'h1010_0000, 32'h1000_0000};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 1'b1, 16'd0, 16'd0, 32'h1020_0000, 32'h1000_0000};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 1'b1, 16'd1, 16'd0, 32'h1010_0000, 32'h1000_0000};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 1'b1, 16'd2, 16'd0, 32'h1020_0000, 32'h1000_0000};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd1, 1'b1, 1'b1, 16'd2, 16'd0, 32'h1020_0000, 32'h1010_0000};
    vt[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd1, 1'b1, 1'b1, 16'd2, 16'd1, 32'h1020_0000, 32'h1010_0000};
    vt[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd1, 1'b1, 1'b1, 16'd2, 16'd2, 32'h1020_0000, 32'h1010_0000};
    vt[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1, 16'd2, 16'd2, 32'h1000_0000, 32'h1010_0000};
    vt[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 1'b1, 1'b1, 16'd2, 16'd2, 32'h1010_0000, 32'h1000_0000};
    vt[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 1'b1, 1'b1, 16'd2, 16'd3, 32'h1010_0000, 32'h1000_0000};

    for (int i = 0; i < 16; i++) begin
      reset = vt[i].rst; enable = vt[i].en; s2mm_sof = vt[i].ws; mm2s_sof = vt[i].rs;
      tick();
      chk($sformatf("vec%0d_wr_idx", i), 32'(wr_idx), 32'(vt[i].w));
      chk($sformatf("vec%0d_rd_idx", i), 32'(rd_idx), 32'(vt[i].r));
      chk($sformatf("vec%0d_valid", i), 32'(rd_frame_valid), 32'(vt[i].v));
      chk($sformatf("vec%0d_s2mm_srn", i), 32'(s2mm_soft_resetn), 32'(vt[i].srn));
      chk($sformatf("vec%0d_mm2s_srn", i), 32'(mm2s_soft_resetn), 32'(vt[i].srn));
      chk($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(vt[i].drop));
      chk($sformatf("vec%0d_repeat", i), 32'(repeat_cnt), 32'(vt[i].rep));
      chk($sformatf("vec%0d_s2mm_addr", i), s2mm_addr, vt[i].wa);
      chk($sformatf("vec%0d_mm2s_addr", i), mm2s_addr, vt[i].ra);
    end

    // Stop with the writer draining for ten cycles; sofs during STOP are ignored.
    s2mm_sof = 1'b0; mm2s_sof = 1'b0; enable = 1'b0; s2mm_resetting = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s2mm_sof = (i == 4); mm2s_sof = (i == 4);
      tick();
      chk($sformatf("drain%0d_srn", i), 32'({s2mm_soft_resetn, mm2s_soft_resetn}), 32'd0);
      chk($sformatf("drain%0d_wr_idx", i), 32'(wr_idx), 32'd1);
      chk($sformatf("drain%0d_rd_idx", i), 32'(rd_idx), 32'd0);
    end
    s2mm_sof = 1'b0; mm2s_sof = 1'b0; s2mm_resetting = 1'b0;
    tick();
    chk("drain_idle_wr_idx", 32'(wr_idx), 32'd0);
    chk("drain_idle_rd_idx", 32'(rd_idx), 32'd2);
    chk("drain_idle_valid", 32'(rd_frame_valid), 32'd0);
    chk("drain_idle_drop", 32'(drop_cnt), 32'd2);
    chk("drain_idle_repeat", 32'(repeat_cnt), 32'd3);

    // Minimum STOP length and re-enable while stopping.
    enable = 1'b1; tick(); chk("reen_run_srn", 32'(s2mm_soft_resetn), 32'd1);
    enable = 1'b0; tick(); chk("reen_stop_srn", 32'(s2mm_soft_resetn), 32'd0);
    enable = 1'b1; tick(); chk("reen_stop1_srn", 32'(mm2s_soft_resetn), 32'd0);
    tick();                chk("reen_idle_srn", 32'(mm2s_soft_resetn), 32'd0);
    tick();                chk("reen_run2_srn", 32'(s2mm_soft_resetn), 32'd1);

    // Reset in the middle of RUN.
    s2mm_sof = 1'b1; tick(); tick();
    reset = 1'b1; tick();
    chk("rst_wr_idx", 32'(wr_idx), 32'd0);
    chk("rst_rd_idx", 32'(rd_idx), 32'd2);
    chk("rst_valid", 32'(rd_frame_valid), 32'd0);
    chk("rst_srn", 32'({s2mm_soft_resetn, mm2s_soft_resetn}), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_repeat", 32'(repeat_cnt), 32'd0);
    chk("rst_s2mm_addr", s2mm_addr, 32'd0);
    chk("rst_mm2s_addr", mm2s_addr, 32'd0);
    reset = 1'b0; s2mm_sof = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      s2mm_sof = ($urandom_range(0, 3) == 0);
      mm2s_sof = ($urandom_range(0, 3) == 0);
      s2mm_resetting = ($urandom_range(0, 2) == 0);
      mm2s_resetting = ($urandom_range(0, 2) == 0);
      if (m_mode == 0 && $urandom_range(0, 7) == 0) begin
        base_addr = $urandom;
        frame_size = $urandom;
      end
      tick();
      check_model(c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
